bp_be_instr_queue: RTL and testbench

- Parametrised instruction queue between fetch and the backend issue stage.
- Accepts up to fetch_width_p RV64 instruction words per cycle, each with its own PC.
- Issues one instruction per cycle as a bp_be_instr_s, with a sign-extended 64-bit immediate and an illegal-encoding flag.
- A flush input empties the queue in one cycle on redirect or exception.

---
 rtl/bp_be_rv64_pkg.sv | 50 +++++
 rtl/bp_be_imm_decode.sv | 28 ++
 rtl/bp_be_instr_queue.sv | 155 +++++++++++++++
 tb/tb_bp_be_instr_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_rv64_pkg.sv
// bp_be_rv64_pkg
// Shared RV64 definitions for the backend: base opcodes, the immediate
// format enumeration, the instruction field view used on issue, and a helper
// that classifies an opcode by immediate format.
// No ports (package).
package bp_be_rv64_pkg;

  localparam logic [6:0] rv64_op_load   = 7'b0000011;
  localparam logic [6:0] rv64_op_imm    = 7'b0010011;
  localparam logic [6:0] rv64_op_imm32  = 7'b0011011;
  localparam logic [6:0] rv64_op_store  = 7'b0100011;
  localparam logic [6:0] rv64_op_branch = 7'b1100011;
  localparam logic [6:0] rv64_op_lui    = 7'b0110111;
  localparam logic [6:0] rv64_op_auipc  = 7'b0010111;
  localparam logic [6:0] rv64_op_jal    = 7'b1101111;
  localparam logic [6:0] rv64_op_jalr   = 7'b1100111;
  localparam logic [6:0] rv64_op_system = 7'b1110011;

  typedef enum logic [2:0] {
    e_imm_i,
    e_imm_s,
    e_imm_b,
    e_imm_u,
    e_imm_j,
    e_imm_none
  } bp_be_imm_fmt_e;

  // R-type field view; other formats reuse the same bit positions.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } bp_be_instr_s;

  function automatic bp_be_imm_fmt_e imm_fmt(input logic [6:0] opcode);
    case (opcode)
      rv64_op_load, rv64_op_imm, rv64_op_imm32,
      rv64_op_jalr, rv64_op_system:       return e_imm_i;
      rv64_op_store:                      return e_imm_s;
      rv64_op_branch:                     return e_imm_b;
      rv64_op_lui, rv64_op_auipc:         return e_imm_u;
      rv64_op_jal:                        return e_imm_j;
      default:                            return e_imm_none;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_imm_decode.sv
// bp_be_imm_decode
// Purely combinational RV64 immediate extraction, shared with the issue stage.
// Ports:
//   instr_i  in  32  instruction word
//   imm_o    out 64  sign-extended immediate (0 for formats without one)
module bp_be_imm_decode
  import bp_be_rv64_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [63:0] imm_o
);

  always_comb begin
    // NOTE: default first so every path assigns imm_o and no latch is inferred.
    imm_o = '0;
    case (imm_fmt(instr_i[6:0]))
      e_imm_i: imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
      e_imm_s: imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      e_imm_b: imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      e_imm_u: imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
      e_imm_j: imm_o = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/bp_be_instr_queue.sv
// bp_be_instr_queue
// Instruction queue between fetch and backend issue. Accepts up to
// fetch_width_p contiguous lanes per enqueue, issues one instruction per
// cycle with its decoded immediate and an illegal-encoding flag. flush_i
// empties the queue in one cycle.
// Optional feature macro: BP_BE_INSTR_QUEUE_BYPASS_EN -- when the queue is
// empty, lane 0 of a firing enqueue is presented on deq_* in the same cycle.
// Ports:
//   clk_i, reset_n_i          clock, async active-low reset
//   flush_i                   discard all entries (overrides enq/deq)
//   enq_v_i / enq_ready_o     enqueue handshake; ready = fetch_width_p slots free
//   enq_lane_v_i              per-lane valid, contiguous from lane 0
//   enq_instr_i               lane instructions, lane 0 in the LSBs
//   enq_pc_i                  PC of lane 0; lane k is at +4k
//   deq_v_o / deq_yumi_i      head valid / consumer takes head
//   deq_instr_o, deq_pc_o     head instruction and PC (0 when empty)
//   deq_imm_o, deq_illegal_o  head immediate and illegal flag
//   count_o                   occupancy
module bp_be_instr_queue
  import bp_be_rv64_pkg::*;
#(
  parameter int els_p         = 8,
  parameter int fetch_width_p = 2,
  parameter int vaddr_width_p = 39
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          flush_i,
  input  logic                          enq_v_i,
  output logic                          enq_ready_o,
  input  logic [fetch_width_p-1:0]      enq_lane_v_i,
  input  logic [32*fetch_width_p-1:0]   enq_instr_i,
  input  logic [vaddr_width_p-1:0]      enq_pc_i,
  output logic                          deq_v_o,
  input  logic                          deq_yumi_i,
  output logic [31:0]                   deq_instr_o,
  output logic [vaddr_width_p-1:0]      deq_pc_o,
  output logic [63:0]                   deq_imm_o,
  output logic                          deq_illegal_o,
  output logic [$clog2(els_p+1)-1:0]    count_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);

  typedef struct packed {
    bp_be_instr_s               instr;
    logic [vaddr_width_p-1:0]   pc;
  } entry_s;

  entry_s             mem_q [els_p];
  entry_s             mem_d [els_p];
  logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]   count_q, count_d, enq_n;
  logic               enq_fire, deq_fire, bypass_v, bypass_take;
  entry_s             head, lane0;
  logic [31:0]        head_instr;

  // Ready depends on the registered count only, so a same-cycle dequeue
  // never opens the door for an enqueue.
  assign enq_ready_o = (int'(count_q) <= els_p - fetch_width_p);
  assign enq_fire    = enq_v_i & enq_ready_o & ~flush_i;

  always_comb begin
    enq_n = '0;
    for (int k = 0; k < fetch_width_p; k++) enq_n = enq_n + cnt_w'(enq_lane_v_i[k]);
  end

  assign lane0 = {enq_instr_i[31:0], enq_pc_i};

`ifdef BP_BE_INSTR_QUEUE_BYPASS_EN
  assign bypass_v = (count_q == '0) & enq_fire & enq_lane_v_i[0];
`else
  assign bypass_v = 1'b0;
`endif
  // A bypassed lane 0 that is consumed the same cycle never touches storage.
  assign bypass_take = bypass_v & deq_yumi_i;

  assign deq_v_o  = (count_q != '0) | bypass_v;
  assign deq_fire = deq_yumi_i & deq_v_o & ~flush_i;

  always_comb begin
    if (count_q != '0)  head = mem_q[rd_ptr_q];
    else if (bypass_v)  head = lane0;
    else                head = '0;
  end

  assign head_instr    = head.instr;
  assign deq_instr_o   = head_instr;
  assign deq_pc_o      = head.pc;
  assign deq_illegal_o = (head.instr.opcode[1:0] != 2'b11);
  assign count_o       = count_q;

  bp_be_imm_decode imm_dec (
    .instr_i (head_instr),
    .imm_o   (deq_imm_o)
  );

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        // Pointer arithmetic is ptr_w wide, so indices wrap modulo els_p.
        for (int k = 0; k < fetch_width_p; k++) begin
          if (enq_lane_v_i[k] && !(k == 0 && bypass_take)) begin
            mem_d[wr_ptr_q + ptr_w'(k) - ptr_w'(bypass_take)] =
              {enq_instr_i[32*k +: 32], enq_pc_i + vaddr_width_p'(4*k)};
          end
        end
        wr_ptr_d = wr_ptr_q + ptr_w'(enq_n) - ptr_w'(bypass_take);
      end
      if (deq_fire && !bypass_take) rd_ptr_d = rd_ptr_q + ptr_w'(1);
      count_d = count_q + (enq_fire ? enq_n : '0) - cnt_w'(deq_fire);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the data array is deliberately not reset; count/pointers alone
  // decide which entries are live, and empty outputs are forced to zero.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  logic [fetch_width_p-1:0] lane_v_inc;
  assign lane_v_inc = enq_lane_v_i + fetch_width_p'(1);

  // Contiguous-from-lane-0 masks have the form 0..01..1: mask & (mask+1) == 0.
  lanes_contiguous_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    enq_fire |-> ((enq_lane_v_i & lane_v_inc) == '0));

  yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    deq_yumi_i |-> deq_v_o);
`endif

endmodule

// File: tb/tb_bp_be_instr_queue.sv
// tb_bp_be_instr_queue
// Directed bench for bp_be_instr_queue (els_p=8, fetch_width_p=2).
// Stimulus pushes expected entries into a scoreboard; a monitor pops and
// compares whenever the head is consumed. Occupancy, ready and valid are
// checked against a small occupancy model after every cycle.
module tb_bp_be_instr_queue;

  localparam int els_lp = 8;
  localparam int fw_lp  = 2;
  localparam int va_lp  = 39;
  localparam int cw_lp  = $clog2(els_lp+1);
`ifdef BP_BE_INSTR_QUEUE_BYPASS_EN
  localparam bit bypass_lp = 1'b1;
`else
  localparam bit bypass_lp = 1'b0;
`endif

  logic                  clk_i, reset_n_i, flush_i, enq_v_i, enq_ready_o;
  logic [fw_lp-1:0]      enq_lane_v_i;
  logic [32*fw_lp-1:0]   enq_instr_i;
  logic [va_lp-1:0]      enq_pc_i, deq_pc_o;
  logic                  deq_v_o, deq_yumi_i, deq_illegal_o;
  logic [31:0]           deq_instr_o;
  logic [63:0]           deq_imm_o;
  logic [cw_lp-1:0]      count_o;

  bp_be_instr_queue #(.els_p(els_lp), .fetch_width_p(fw_lp), .vaddr_width_p(va_lp)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .flush_i       (flush_i),
    .enq_v_i       (enq_v_i),
    .enq_ready_o   (enq_ready_o),
    .enq_lane_v_i  (enq_lane_v_i),
    .enq_instr_i   (enq_instr_i),
    .enq_pc_i      (enq_pc_i),
    .deq_v_o       (deq_v_o),
    .deq_yumi_i    (deq_yumi_i),
    .deq_instr_o   (deq_instr_o),
    .deq_pc_o      (deq_pc_o),
    .deq_imm_o     (deq_imm_o),
    .deq_illegal_o (deq_illegal_o),
    .count_o       (count_o)
  );

  typedef struct {
    logic [31:0]      instr;
    logic [va_lp-1:0] pc;
    logic [63:0]      imm;
    logic             ill;
  } exp_s;

  exp_s        sb[$];
  logic [31:0] tab_instr [8];
  logic [63:0] tab_imm   [8];
  logic        tab_ill   [8];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          seq     = 0;
  int          m_count = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed head must match the oldest expected entry.
  always @(negedge clk_i) begin : monitor
    exp_s e;
    if (reset_n_i && deq_v_o && deq_yumi_i && !flush_i) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: dequeued pc %h, expected nothing queued", deq_pc_o);
      end else begin
        e = sb.pop_front();
        check("deq_pc", 64'(deq_pc_o), 64'(e.pc));
        check("deq_instr", 64'(deq_instr_o), 64'(e.instr));
        check("deq_imm", deq_imm_o, e.imm);
        check("deq_illegal", 64'(deq_illegal_o), 64'(e.ill));
      end
    end
  end

  task automatic idle();
    enq_v_i      = 1'b0;
    enq_lane_v_i = '0;
    enq_instr_i  = '0;
    enq_pc_i     = '0;
    deq_yumi_i   = 1'b0;
    flush_i      = 1'b0;
  endtask

  // One clock of stimulus; entered and left at posedge+2.
  task automatic step(input bit ev, input logic [1:0] lanes, input logic [va_lp-1:0] pc,
                      input bit yumi, input bit flush);
    bit fire, exp_v_pre;
    int n;
    enq_v_i      = ev;
    enq_lane_v_i = lanes;
    enq_pc_i     = pc;
    enq_instr_i  = {tab_instr[(seq+1)%8], tab_instr[seq%8]};
    deq_yumi_i   = yumi;
    flush_i      = flush;
    fire      = ev && (m_count <= els_lp - fw_lp) && !flush;
    n         = int'(lanes[0]) + int'(lanes[1]);
    exp_v_pre = (m_count != 0) || (bypass_lp && m_count == 0 && fire && lanes[0]);
    if (fire) begin
      for (int k = 0; k < fw_lp; k++) begin
        if (lanes[k]) begin
          sb.push_back('{tab_instr[seq%8], pc + va_lp'(4*k), tab_imm[seq%8], tab_ill[seq%8]});
          seq++;
        end
      end
    end
    #1;
    check("enq_ready", 64'(enq_ready_o), 64'(m_count <= els_lp - fw_lp));
    check("deq_v_pre", 64'(deq_v_o), 64'(exp_v_pre));
    if (flush) m_count = 0;
    else       m_count = m_count + (fire ? n : 0) - (yumi ? 1 : 0);
    @(posedge clk_i);
    #1;
    idle();
    if (flush) sb.delete();
    #1;
    check("count", 64'(count_o), 64'(m_count));
    check("deq_v", 64'(deq_v_o), 64'(m_count != 0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    // Hand-decoded instruction table: word, immediate, illegal.
    tab_instr[0] = 32'hFFF00093; tab_imm[0] = 64'hFFFF_FFFF_FFFF_FFFF; tab_ill[0] = 1'b0; // addi -1
    tab_instr[1] = 32'h00112623; tab_imm[1] = 64'd12;                  tab_ill[1] = 1'b0; // sw 12
    tab_instr[2] = 32'hFE000EE3; tab_imm[2] = 64'hFFFF_FFFF_FFFF_FFFC; tab_ill[2] = 1'b0; // beq -4
    tab_instr[3] = 32'h123452B7; tab_imm[3] = 64'h0000_0000_1234_5000; tab_ill[3] = 1'b0; // lui
    tab_instr[4] = 32'h00000013; tab_imm[4] = 64'd0;                   tab_ill[4] = 1'b0; // nop
    tab_instr[5] = 32'h00000001; tab_imm[5] = 64'd0;                   tab_ill[5] = 1'b1; // compressed
    tab_instr[6] = 32'hFF9FF06F; tab_imm[6] = 64'hFFFF_FFFF_FFFF_FFF8; tab_ill[6] = 1'b0; // jal -8
    tab_instr[7] = 32'h00001097; tab_imm[7] = 64'h0000_0000_0000_1000; tab_ill[7] = 1'b0; // auipc

    idle();
    reset_n_i = 1'b0;
    #12;
    check("rst_deq_v", 64'(deq_v_o), 64'd0);
    check("rst_ready", 64'(enq_ready_o), 64'd1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_pc", 64'(deq_pc_o), 64'd0);
    check("rst_instr", 64'(deq_instr_o), 64'd0);
    check("rst_imm", deq_imm_o, 64'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #2;

    // Fill and drain.
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, va_lp'(32'h1000 + 8*i), 1'b0, 1'b0);
    check("full_ready", 64'(enq_ready_o), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00, '0, 1'b1, 1'b0);

    // Pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, va_lp'(32'h2000 + 8*i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, va_lp'(32'h3000 + 8*i), 1'b0, 1'b0);
    check("wrap_count", 64'(count_o), 64'd7);
    for (int i = 0; i < 7; i++) step(1'b0, 2'b00, '0, 1'b1, 1'b0);

    // Simultaneous enqueue and dequeue at count 4.
    step(1'b1, 2'b11, va_lp'(32'h4000), 1'b0, 1'b0);
    step(1'b1, 2'b11, va_lp'(32'h4008), 1'b0, 1'b0);
    step(1'b1, 2'b11, va_lp'(32'h4010), 1'b1, 1'b0);
    check("simul_head", 64'(deq_pc_o), 64'h4004);

    // Single lane, then an empty lane mask (no-op).
    step(1'b1, 2'b01, va_lp'(32'h5000), 1'b0, 1'b0);
    step(1'b1, 2'b00, va_lp'(32'h5100), 1'b0, 1'b0);

    // Flush at count 6 with enqueue and yumi in the same cycle.
    step(1'b1, 2'b11, va_lp'(32'h6000), 1'b1, 1'b1);
    check("flush_pc", 64'(deq_pc_o), 64'd0);
    check("flush_imm", deq_imm_o, 64'd0);
    step(1'b1, 2'b11, va_lp'(32'h7000), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 2'b00, '0, 1'b1, 1'b0);

    // Asynchronous reset with five entries resident.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, va_lp'(32'h8000 + 8*i), 1'b0, 1'b0);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0);
    #1;
    reset_n_i = 1'b0;
    #1;
    check("arst_deq_v", 64'(deq_v_o), 64'd0);
    check("arst_ready", 64'(enq_ready_o), 64'd1);
    check("arst_count", 64'(count_o), 64'd0);
    sb.delete();
    m_count = 0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #2;
    check("post_rst_deq_v", 64'(deq_v_o), 64'd0);
    check("post_rst_count", 64'(count_o), 64'd0);
    step(1'b1, 2'b11, va_lp'(32'h9000), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 2'b00, '0, 1'b1, 1'b0);

`ifdef BP_BE_INSTR_QUEUE_BYPASS_EN
    // Empty queue, enqueue and yumi in the same cycle.
    step(1'b1, 2'b11, va_lp'(32'hA000), 1'b1, 1'b0);
    check("bypass_count", 64'(count_o), 64'd1);
    step(1'b0, 2'b00, '0, 1'b1, 1'b0);
`endif

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
